// File: rtl/lcis_scan_ctrl.sv
// Single-port RAM sequencer: host loads the array, then a scan reports the longest strictly
// increasing contiguous run. Define LCIS_SIGNED_EN for a two's-complement element comparison.
module lcis_scan_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  host_wr_valid,
    output logic                  host_wr_ready,
    input  logic [ADDR_WIDTH-1:0] host_wr_addr,
    input  logic [DATA_WIDTH-1:0] host_wr_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] result,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_write_req,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] issue_q, issue_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [ADDR_WIDTH-1:0] best_q, best_d;
    logic [ADDR_WIDTH-1:0] result_q, result_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                  pend_q, pend_d;

    logic                  gt;
    logic [ADDR_WIDTH-1:0] cur_upd, best_upd;

    always_comb begin
`ifdef LCIS_SIGNED_EN
        gt = $signed(ram_dout) > $signed(prev_q);
`else
        gt = ram_dout > prev_q;
`endif
        cur_upd  = cur_q;
        best_upd = best_q;
        // cur_q == 0 only before the first element, so it doubles as the first-element flag
        if (pend_q) begin
            cur_upd  = (cur_q != '0 && gt) ? cur_q + ONE : ONE;
            best_upd = (cur_upd > best_q) ? cur_upd : best_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        issue_d  = issue_q;
        len_d    = len_q;
        cur_d    = cur_upd;
        best_d   = best_upd;
        result_d = result_q;
        prev_d   = pend_q ? ram_dout : prev_q;
        pend_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    issue_d = '0;
                    cur_d   = '0;
                    best_d  = '0;
                    len_d   = len;
                    if (len == '0) begin
                        state_d  = S_DONE;
                        result_d = '0;
                    end else begin
                        state_d = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                pend_d = 1'b1;
                if (issue_q == len_q - ONE) state_d = S_DRAIN;
                else                        issue_d = issue_q + ONE;
            end
            S_DRAIN: begin
                state_d  = S_DONE;
                result_d = best_upd;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            issue_q  <= '0;
            len_q    <= '0;
            cur_q    <= '0;
            best_q   <= '0;
            result_q <= '0;
            prev_q   <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            issue_q  <= issue_d;
            len_q    <= len_d;
            cur_q    <= cur_d;
            best_q   <= best_d;
            result_q <= result_d;
            prev_q   <= prev_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        host_wr_ready = (state_q == S_IDLE);
        busy          = (state_q == S_SCAN) || (state_q == S_DRAIN);
        done          = (state_q == S_DONE);
        result        = result_q;
        if (state_q == S_IDLE) begin
            ram_addr      = host_wr_addr;
            ram_din       = host_wr_data;
            ram_write_req = host_wr_valid;
        end else begin
            ram_addr      = issue_q;
            ram_din       = '0;
            ram_write_req = 1'b0;
        end
    end

endmodule

// File: tb/tb_lcis_scan_ctrl.sv
// Scoreboard bench for lcis_scan_ctrl with a behavioural single-port RAM (1-cycle read latency).
module tb_lcis_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_wr_valid = 1'b0;
    logic        host_wr_ready;
    logic [15:0] host_wr_addr = '0;
    logic [15:0] host_wr_data = '0;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [15:0] ram_addr;
    logic [15:0] ram_din;
    logic        ram_write_req;
    logic [15:0] ram_dout = '0;

    logic [15:0] mem   [0:65535];
    logic [15:0] model [0:255];

    int unsigned sb[$];
    int n_pass  = 0;
    int n_total = 0;
    int n_done  = 0;
    int n_scans = 0;

    lcis_scan_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .start(start), .len(len),
        .busy(busy), .done(done), .result(result),
        .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_write_req(ram_write_req), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write_req) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit elem_gt(input logic [15:0] a, input logic [15:0] b);
`ifdef LCIS_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    function automatic int unsigned lcis(input int n);
        int unsigned cur = 0, best = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && elem_gt(model[i], model[i-1])) cur++;
            else cur = 1;
            if (cur > best) best = cur;
        end
        return best;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (sb.size() == 0) check("unexpected_done", {31'd0, done}, 32'd0);
            else check("result", {16'd0, result}, sb.pop_front());
        end
    end

    task automatic host_write(input logic [15:0] a, input logic [15:0] d);
        host_wr_valid = 1'b1;
        host_wr_addr  = a;
        host_wr_data  = d;
        model[a]      = d;
        @(posedge clk); #1;
        host_wr_valid = 1'b0;
    endtask

    // Caller may pre-set host_wr_* (and model) to write in the start cycle.
    task automatic run_scan(input int n, input bit poke, input bit restart);
        int k, bcnt, exp_lat;
        start = 1'b1;
        len   = 16'(n);
        sb.push_back(lcis(n));
        n_scans++;
        @(posedge clk); #1;
        start = 1'b0;
        host_wr_valid = 1'b0;
        k = 0;
        bcnt = 0;
        while (!done && k < 200) begin
            if (busy) bcnt++;
            if (poke && k == 2) begin
                host_wr_valid = 1'b1;
                host_wr_addr  = 16'd3;
                host_wr_data  = 16'd0;
                #1;
                check("busy_ready", {31'd0, host_wr_ready}, 32'd0);
                check("busy_wreq", {31'd0, ram_write_req}, 32'd0);
            end
            if (poke && k == 3) host_wr_valid = 1'b0;
            if (restart && k == 2) begin
                start = 1'b1;
                len   = 16'd3;
            end
            if (restart && k == 3) start = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        exp_lat = (n == 0) ? 0 : n + 1;
        check("done_latency", k, exp_lat);
        check("busy_cycles", bcnt, exp_lat);
        @(posedge clk); #1;
        check("done_pulse", {31'd0, done}, 32'd0);
        check("idle_ready", {31'd0, host_wr_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] a5 [0:4];
        a5 = '{16'd1, 16'd3, 16'd5, 16'd4, 16'd7};

        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_wreq", {31'd0, ram_write_req}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready0", {31'd0, host_wr_ready}, 32'd1);

        for (int i = 0; i < 5; i++) host_write(16'(i), a5[i]);
        run_scan(5, 1'b0, 1'b0);

        // write in the same cycle as start: [1,3,5,6,7]
        host_wr_valid = 1'b1;
        host_wr_addr  = 16'd3;
        host_wr_data  = 16'd6;
        model[3]      = 16'd6;
        run_scan(5, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) host_write(16'(i), 16'd2);
        run_scan(4, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) host_write(16'(i), 16'(i));
        run_scan(8, 1'b1, 1'b0);
        run_scan(8, 1'b0, 1'b0);

        run_scan(0, 1'b0, 1'b0);
        check("len0_result", {16'd0, result}, 32'd0);

        run_scan(5, 1'b0, 1'b1);

        // reset in the middle of a scan
        start = 1'b1;
        len   = 16'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_result", {16'd0, result}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_scan(5, 1'b0, 1'b0);

        host_write(16'd0, 16'hFFFF);
        host_write(16'd1, 16'h0001);
        run_scan(2, 1'b0, 1'b0);

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("done_count", n_done, n_scans);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
